// File: rtl/dram_cmd_responder.sv
// Device-side DRAM responder: decodes PRE/ACT/RD/WR on the raw pins, tracks the open row
// and tRP/tRCD timing, serves reads from a reduced store after a fixed CAS latency.
module dram_cmd_responder #(
    parameter int ROW_W         = 11,
    parameter int COL_W         = 10,
    parameter int DATA_W        = 32,
    parameter int MEM_ROW_BITS  = 4,
    parameter int MEM_COL_BITS  = 8,
    parameter int CL            = 3,
    parameter int T_RP          = 4,
    parameter int T_RCD         = 3,
    parameter bit OPEN_ON_RESET = 1'b1
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                CSn,
    input  logic                RASn,
    input  logic                CASn,
    input  logic [DATA_W/8-1:0] WEn,
    input  logic [ROW_W-1:0]    A,
    input  logic [DATA_W-1:0]   D,
    output logic [DATA_W-1:0]   Q,
    output logic                VALID,
    output logic                row_open,
    output logic [ROW_W-1:0]    open_row,
    output logic                err_cmd,
    output logic                err_timing
);

    localparam int LANES     = DATA_W / 8;
    localparam int COL_IDX_W = (MEM_COL_BITS < COL_W) ? MEM_COL_BITS : COL_W;
    localparam int IDX_W     = MEM_ROW_BITS + COL_IDX_W;
    localparam int T_MAX     = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int TIMER_W   = $clog2(T_MAX + 1);

    typedef enum logic [1:0] {ST_CLOSED, ST_PRE_WAIT, ST_ACT_WAIT, ST_OPEN} state_t;
    typedef enum logic [2:0] {CMD_NOP, CMD_PRE, CMD_ACT, CMD_RD, CMD_WR, CMD_ILL} cmd_t;

    state_t             state, state_nxt;
    cmd_t               cmd;
    logic [TIMER_W-1:0] timer;
    logic               rp_done, rcd_done;
    logic               rd_go, wr_go, act_latch, err_cmd_set, err_tim_set;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]  mem [2**IDX_W];
    logic [CL-1:0]      pipe_v;
    logic [DATA_W-1:0]  pipe_d [CL];

    // NOTE: every variable assigned in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cmd = CMD_NOP;
        if (!CSn) begin
            case ({RASn, CASn})
                2'b11: cmd = CMD_NOP;
                2'b01: begin
                    if (WEn == '0)      cmd = CMD_PRE;
                    else if (&WEn)      cmd = CMD_ACT;
                    else                cmd = CMD_ILL;
                end
                2'b10:   cmd = (&WEn) ? CMD_RD : CMD_WR;
                default: cmd = CMD_ILL;
            endcase
        end
    end

    // A wait state counts as done on the edge where T cycles have elapsed since its command.
    assign rp_done  = (state == ST_PRE_WAIT) && (timer >= TIMER_W'(T_RP - 1));
    assign rcd_done = (state == ST_ACT_WAIT) && (timer >= TIMER_W'(T_RCD - 1));

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) state <= OPEN_ON_RESET ? ST_OPEN : ST_CLOSED;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_PRE_WAIT: if (rp_done)  state_nxt = ST_CLOSED;
            ST_ACT_WAIT: if (rcd_done) state_nxt = ST_OPEN;
            default: ;
        endcase
        case (cmd)
            CMD_PRE: state_nxt = ST_PRE_WAIT;
            CMD_ACT: state_nxt = ST_ACT_WAIT;
            default: ;
        endcase
    end

    always_comb begin
        row_open    = (state == ST_ACT_WAIT) || (state == ST_OPEN);
        rd_go       = 1'b0;
        wr_go       = 1'b0;
        act_latch   = 1'b0;
        err_cmd_set = 1'b0;
        err_tim_set = 1'b0;
        case (cmd)
            CMD_ACT: begin
                act_latch   = 1'b1;
                err_tim_set = (state == ST_PRE_WAIT) && !rp_done;
                err_cmd_set = (state == ST_ACT_WAIT) || (state == ST_OPEN);
            end
            CMD_RD, CMD_WR: begin
                if ((state == ST_OPEN) || (state == ST_ACT_WAIT)) begin
                    rd_go       = (cmd == CMD_RD);
                    wr_go       = (cmd == CMD_WR);
                    err_tim_set = (state == ST_ACT_WAIT) && !rcd_done;
                end else begin
                    err_cmd_set = 1'b1;
                end
            end
            CMD_ILL: err_cmd_set = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn)                            timer <= '0;
        else if (cmd == CMD_PRE || cmd == CMD_ACT) timer <= '0;
        else if (state == ST_PRE_WAIT || state == ST_ACT_WAIT) timer <= timer + 1'b1;
        else                                     timer <= '0;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            open_row   <= '0;
            err_cmd    <= 1'b0;
            err_timing <= 1'b0;
        end else begin
            if (act_latch)   open_row   <= A;
            if (err_cmd_set) err_cmd    <= 1'b1;
            if (err_tim_set) err_timing <= 1'b1;
        end
    end

    assign idx     = {open_row[MEM_ROW_BITS-1:0], A[COL_IDX_W-1:0]};
    assign rd_data = mem[idx];

    // NOTE: storage arrays carry no reset; contents survive reset and the data path is qualified by valid bits.
    always_ff @(posedge ACLK) begin
        if (ARESETn && wr_go) begin
            for (int i = 0; i < LANES; i++) begin
                if (!WEn[i]) mem[idx][8*i +: 8] <= D[8*i +: 8];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        pipe_d[0] <= rd_data;
        for (int i = 1; i < CL; i++) pipe_d[i] <= pipe_d[i-1];
    end

    // Valid bits flush on reset so in-flight reads are dropped; Q holds between pulses.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            pipe_v <= '0;
            VALID  <= 1'b0;
            Q      <= '0;
        end else begin
            pipe_v[0] <= rd_go;
            for (int i = 1; i < CL; i++) pipe_v[i] <= pipe_v[i-1];
            VALID <= pipe_v[CL-1];
            if (pipe_v[CL-1]) Q <= pipe_d[CL-1];
        end
    end

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Directed bench for dram_cmd_responder with default parameters (CL=3, tRP=4, tRCD=3, row 0 open on reset).
module tb_dram_cmd_responder;

    localparam int CL = 3;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        CSn = 1'b1, RASn = 1'b1, CASn = 1'b1;
    logic [3:0]  WEn = 4'hF;
    logic [10:0] A = '0;
    logic [31:0] D = '0;
    logic [31:0] Q;
    logic        VALID, row_open, err_cmd, err_timing;
    logic [10:0] open_row;

    int checks = 0;
    int failures = 0;

    dram_cmd_responder dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .CSn(CSn), .RASn(RASn), .CASn(CASn),
        .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID), .row_open(row_open),
        .open_row(open_row), .err_cmd(err_cmd), .err_timing(err_timing)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one command for exactly one rising edge, then return to NOP; ends on the next falling edge.
    task automatic drive(input logic ras, input logic cas, input logic [3:0] we,
                         input logic [10:0] a, input logic [31:0] d);
        CSn = 1'b0; RASn = ras; CASn = cas; WEn = we; A = a; D = d;
        @(posedge ACLK);
        #1;
        CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF;
        @(negedge ACLK);
    endtask

    task automatic do_pre();                         drive(1'b0, 1'b1, 4'h0, '0, '0); endtask
    task automatic do_act(input logic [10:0] row);   drive(1'b0, 1'b1, 4'hF, row, '0); endtask
    task automatic do_rd(input logic [10:0] col);    drive(1'b1, 1'b0, 4'hF, col, '0); endtask
    task automatic do_wr(input logic [10:0] col, input logic [31:0] d, input logic [3:0] we);
        drive(1'b1, 1'b0, we, col, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ACLK);
            @(negedge ACLK);
        end
    endtask

    task automatic apply_reset();
        ARESETn = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    // Wait (bounded) for VALID; 'start' is how many cycles have already passed since the RD edge.
    task automatic expect_read(input string tag, input int start, input logic [31:0] exp);
        int lat = start;
        while (VALID !== 1'b1 && lat < 10) begin
            @(negedge ACLK);
            lat++;
        end
        check({tag, " latency"}, lat, CL);
        check({tag, " data"}, Q, exp);
    endtask

    task automatic no_valid(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            if (VALID === 1'b1) seen++;
            @(negedge ACLK);
        end
        check(tag, seen, 0);
    endtask

    initial begin
        apply_reset();
        check("reset VALID", VALID, 0);
        check("reset Q", Q, 0);
        check("reset err_cmd", err_cmd, 0);
        check("reset err_timing", err_timing, 0);
        check("reset row_open", row_open, 1);
        check("reset open_row", open_row, 0);

        // Full write then read-after-write on the next cycle.
        do_wr(11'h004, 32'hDEADBEEF, 4'h0);
        do_rd(11'h004);
        expect_read("raw", 0, 32'hDEADBEEF);
        @(negedge ACLK);
        check("pulse width", VALID, 0);
        check("Q hold", Q, 32'hDEADBEEF);

        // A write behind an in-flight read must not change the returned data.
        do_rd(11'h004);
        do_wr(11'h004, 32'h12345678, 4'h0);
        expect_read("inflight", 1, 32'hDEADBEEF);
        do_rd(11'h004);
        expect_read("after inflight", 0, 32'h12345678);

        // Byte lanes: WEn=1010 writes lanes 0 and 2 only.
        do_wr(11'h010, 32'h11223344, 4'h0);
        do_wr(11'h010, 32'hAABBCCDD, 4'b1010);
        do_rd(11'h010);
        expect_read("byte write", 0, 32'h11BB33DD);

        // Back-to-back reads, cols 0..3.
        for (int i = 0; i < 4; i++) do_wr(11'(i), 32'h1000_0000 + i, 4'h0);
        for (int i = 0; i < 4; i++) do_rd(11'(i));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("burst valid %0d", i), VALID, 1);
            check($sformatf("burst data %0d", i), Q, 32'h1000_0000 + i);
            @(negedge ACLK);
        end
        check("burst end", VALID, 0);

        // Row switch at exact tRP / tRCD boundaries.
        do_pre();
        check("pre row_open", row_open, 0);
        idle(3);
        do_act(11'h005);
        check("act row_open", row_open, 1);
        check("act open_row", open_row, 11'h005);
        idle(2);
        do_wr(11'h001, 32'h0000_0001, 4'h0);
        do_pre(); idle(3); do_act(11'h000); idle(2);
        do_rd(11'h001);
        expect_read("row0 col1", 0, 32'h1000_0001);
        do_pre(); idle(3); do_act(11'h005); idle(2);
        do_rd(11'h001);
        expect_read("row5 col1", 0, 32'h0000_0001);
        check("switch err_cmd", err_cmd, 0);
        check("switch err_timing", err_timing, 0);

        // tRP violation, then tRCD violation: both execute.
        do_pre(); idle(1); do_act(11'h000);
        check("trp err_timing", err_timing, 1);
        check("trp open_row", open_row, 11'h000);
        check("trp row_open", row_open, 1);
        do_rd(11'h001);
        expect_read("trcd read", 0, 32'h1000_0001);
        check("trcd err_timing", err_timing, 1);
        check("trcd err_cmd", err_cmd, 0);

        // Illegal RAS+CAS.
        apply_reset();
        check("rst clears err_timing", err_timing, 0);
        drive(1'b0, 1'b0, 4'hF, 11'h004, '0);
        check("ras_cas err_cmd", err_cmd, 1);
        check("ras_cas err_timing", err_timing, 0);
        no_valid("ras_cas no VALID", 10);

        // RASn=0 with mixed WEn.
        apply_reset();
        check("rst clears err_cmd", err_cmd, 0);
        drive(1'b0, 1'b1, 4'b0101, 11'h000, '0);
        check("mixed WEn err_cmd", err_cmd, 1);
        check("mixed WEn row_open", row_open, 1);

        // Read while closed.
        apply_reset();
        do_pre(); idle(5);
        do_rd(11'h004);
        check("closed rd err_cmd", err_cmd, 1);
        check("closed row_open", row_open, 0);
        no_valid("closed rd no VALID", 10);

        // ACT on an open row without precharge.
        apply_reset();
        do_act(11'h003);
        check("act open err_cmd", err_cmd, 1);
        check("act open open_row", open_row, 11'h003);

        // Reset in the middle of a burst drops the rest.
        apply_reset();
        for (int i = 0; i < 4; i++) do_rd(11'(i));
        check("mid burst first valid", VALID, 1);
        check("mid burst first data", Q, 32'h1000_0000);
        ARESETn = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        check("mid reset VALID", VALID, 0);
        check("mid reset Q", Q, 0);
        ARESETn = 1'b1;
        no_valid("mid reset no pulses", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
